// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bundle: instruction-memory req/gnt/rvalid channel plus the decode-side head/stall/redirect signals.
// master = fetch stage, slave = instruction memory and decode.
interface if_fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic [31:0] id_instruction;
    logic [31:0] id_pc_4;
    logic        id_stall;
    logic        id_redirect;
    logic [31:0] id_redirect_pc;
    logic        if_err;

    modport master (
        output imem_req, imem_addr, id_valid, id_instruction, id_pc_4, if_err,
        input  imem_gnt, imem_rvalid, imem_rdata, id_stall, id_redirect, id_redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, id_valid, id_instruction, id_pc_4, if_err,
        output imem_gnt, imem_rvalid, imem_rdata, id_stall, id_redirect, id_redirect_pc
    );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction fetch: sequential req/gnt fetch into a DEPTH-entry FIFO, head shown to decode; 2 cycles reset/redirect to id_valid.
// Decode stall holds the head and throttles requests via occupancy+outstanding; redirect flushes and kills in-flight words.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic             clk,
    input  logic             rst,
    if_fetch_stage_if.master bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    typedef logic [CW-1:0] cnt_t;
    typedef logic [PW-1:0] ptr_t;
    typedef struct packed {
        logic [31:0] pc_4;
        logic [31:0] instruction;
    } entry_t;

    entry_t      mem [DEPTH];
    entry_t      head;
    ptr_t        rd_ptr, wr_ptr;
    cnt_t        occupancy, outstanding, kill;
    logic [31:0] fetch_pc, resp_pc, target;
    logic [CW:0] inflight;
    logic        err;
    logic        valid, take_redirect, req, hs, rsp, drop, push, pop;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        valid         = (occupancy != '0);
        take_redirect = bus.id_redirect && valid && !bus.id_stall;
        inflight      = {1'b0, occupancy} + {1'b0, outstanding};
        req           = !rst && !take_redirect && (inflight < (CW+1)'(DEPTH));
        hs            = req && bus.imem_gnt;
        // A response with nothing outstanding is spurious and must not touch any counter.
        rsp           = bus.imem_rvalid && (outstanding != '0);
        drop          = rsp && (kill != '0);
        push          = rsp && !drop && !take_redirect;
        pop           = valid && !bus.id_stall;
        target        = {bus.id_redirect_pc[31:2], 2'b00};
        head          = mem[rd_ptr];
    end

    assign bus.imem_req       = req;
    assign bus.imem_addr      = fetch_pc;
    assign bus.id_valid       = valid;
    assign bus.id_instruction = valid ? head.instruction : 32'h0;
    assign bus.id_pc_4        = valid ? head.pc_4 : 32'h0;
    assign bus.if_err         = err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            kill        <= '0;
            occupancy   <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            err         <= 1'b0;
        end else begin
            if (bus.imem_rvalid && outstanding == '0) begin
                err <= 1'b1;
            end
            outstanding <= outstanding + cnt_t'(hs) - cnt_t'(rsp);
            if (take_redirect) begin
                // Everything still in flight after this cycle belongs to the wrong path.
                fetch_pc  <= target;
                resp_pc   <= target;
                kill      <= outstanding - cnt_t'(rsp);
                occupancy <= '0;
                rd_ptr    <= '0;
                wr_ptr    <= '0;
            end else begin
                if (hs) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (drop) begin
                    kill <= kill - 1'b1;
                end
                if (push) begin
                    resp_pc <= resp_pc + 32'd4;
                    wr_ptr  <= ptr_inc(wr_ptr);
                end
                if (pop) begin
                    rd_ptr <= ptr_inc(rd_ptr);
                end
                occupancy <= occupancy + cnt_t'(push) - cnt_t'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {resp_pc + 32'd4, bus.imem_rdata};
        end
    end

    push_to_full: assert property (@(posedge clk) disable iff (rst)
        !(push && occupancy == cnt_t'(DEPTH)));

endmodule
